// File: rtl/spi_regbank.sv
// SPI mode-0 slave register bank. The SPI pins are oversampled on clk, a frame carries
// R/W + address followed by burst data words, and the registers appear as a flat image.
//
// state  | meaning
// S_IDLE | waiting for a synchronised select fall
// S_CMD  | shifting in the R/W bit and the address
// S_DATA | shifting data words in (write) or out (read), pointer advances per word
module spi_regbank #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 7,
   parameter int NUM_REGS    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       SCLK,
   input  logic                       SI,
   input  logic                       SV_n,
   output logic                       SO,
   output logic                       so_oe,
   output logic [NUM_REGS*DATA_W-1:0] regs,
   output logic [NUM_REGS-1:0]        wr_strobe,
   output logic                       busy
);

   localparam int MAXB  = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
   localparam int CNT_W = $clog2(MAXB + 1);

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA} state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q, si_sync_q, sv_sync_q, fill_q;
   logic                   sclk_prev_q, sv_prev_q, arm_q;
   logic                   sclk_s, si_s, sv_s;
   logic                   sclk_rise, sclk_fall, sv_fall, sv_rise;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
   logic [MAXB-2:0]        shift_q, shift_d;
   logic [MAXB-1:0]        shift_nxt;
   logic [ADDR_W-1:0]      ptr_q, ptr_d;
   logic                   rw_q, rw_d;
   logic [DATA_W-1:0]      sout_q, sout_d;
   logic                   so_oe_q, so_oe_d;
   logic                   pend_q, pend_d;
   logic [ADDR_W-1:0]      pend_addr_q, pend_addr_d;
   logic [DATA_W-1:0]      pend_data_q, pend_data_d;

   logic [DATA_W-1:0]      regs_q [NUM_REGS];
   logic [NUM_REGS-1:0]    wr_strobe_q;
   logic [DATA_W-1:0]      rd_word;
   logic                   ptr_ok;

   assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
   assign si_s   = si_sync_q[SYNC_STAGES-1];
   assign sv_s   = sv_sync_q[SYNC_STAGES-1];

   assign sclk_rise = sclk_s & ~sclk_prev_q;
   assign sclk_fall = ~sclk_s & sclk_prev_q;
   assign sv_rise   = sv_s & ~sv_prev_q;
   // arm_q blocks the false select fall seen when SV_n is still low coming out of reset
   assign sv_fall   = arm_q & sv_prev_q & ~sv_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q <= '0;
         si_sync_q   <= '0;
         sv_sync_q   <= '1;
         fill_q      <= '0;
         sclk_prev_q <= 1'b0;
         sv_prev_q   <= 1'b1;
         arm_q       <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
         si_sync_q   <= {si_sync_q[SYNC_STAGES-2:0], SI};
         sv_sync_q   <= {sv_sync_q[SYNC_STAGES-2:0], SV_n};
         fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         sclk_prev_q <= sclk_s;
         sv_prev_q   <= sv_s;
         if (fill_q[SYNC_STAGES-1] && sv_s) arm_q <= 1'b1;
      end
   end

   assign ptr_ok = ({1'b0, ptr_q} < (ADDR_W+1)'(NUM_REGS));

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (ptr_q == ADDR_W'(i)) rd_word = regs_q[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      rw_d        = rw_q;
      sout_d      = sout_q;
      so_oe_d     = so_oe_q;
      pend_d      = 1'b0;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      shift_nxt   = {shift_q, si_s};

      case (state_q)
         S_IDLE: begin
            if (sv_fall) begin
               state_d   = S_CMD;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         S_CMD: begin
            if (sclk_rise) begin
               shift_d = shift_nxt[MAXB-2:0];
               if (bit_cnt_q == CNT_W'(ADDR_W)) begin
                  rw_d      = shift_nxt[ADDR_W];
                  ptr_d     = shift_nxt[ADDR_W-1:0];
                  bit_cnt_d = '0;
                  state_d   = S_DATA;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
         end
         S_DATA: begin
            if (sclk_rise) begin
               shift_d = shift_nxt[MAXB-2:0];
               if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
                  ptr_d     = ptr_q + ADDR_W'(1);
                  if (!rw_q && ptr_ok) begin
                     pend_d      = 1'b1;
                     pend_addr_d = ptr_q;
                     pend_data_d = shift_nxt[DATA_W-1:0];
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
               end
            end
            // bit_cnt == 0 on a fall means a new word starts: load it, else shift
            if (sclk_fall && rw_q) begin
               so_oe_d = 1'b1;
               if (bit_cnt_q == '0) sout_d = ptr_ok ? rd_word : '0;
               else                 sout_d = {sout_q[DATA_W-2:0], 1'b0};
            end
         end
         default: state_d = S_IDLE;
      endcase

      // a word finished on this same clk keeps its pending commit
      if (sv_rise) begin
         state_d   = S_IDLE;
         bit_cnt_d = '0;
         shift_d   = '0;
         sout_d    = '0;
         so_oe_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ptr_q       <= '0;
         rw_q        <= 1'b0;
         sout_q      <= '0;
         so_oe_q     <= 1'b0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         pend_data_q <= '0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         rw_q        <= rw_d;
         sout_q      <= sout_d;
         so_oe_q     <= so_oe_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_strobe_q <= '0;
      end else begin
         wr_strobe_q <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            if (pend_q && pend_addr_q == ADDR_W'(i)) begin
               regs_q[i]      <= pend_data_q;
               wr_strobe_q[i] <= 1'b1;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign wr_strobe = wr_strobe_q;
   assign busy      = (state_q != S_IDLE);
   assign so_oe     = so_oe_q;
   assign SO        = so_oe_q & sout_q[DATA_W-1];

endmodule

// File: tb/tb_spi_regbank.sv
// Self-checking bench for spi_regbank: directed frames plus random frames against a
// register-array model of the SPI protocol.
module tb_spi_regbank;
   localparam int DATA_W      = 8;
   localparam int ADDR_W      = 7;
   localparam int NUM_REGS    = 8;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 6;

   logic clk = 1'b0;
   logic rst, SCLK, SI, SV_n, SO, so_oe, busy;
   logic [NUM_REGS*DATA_W-1:0] regs;
   logic [NUM_REGS-1:0]        wr_strobe;

   int n_checks = 0;
   int n_pass   = 0;

   logic [DATA_W-1:0]   model [NUM_REGS];
   logic [63:0]         exp_pk;
   int                  exp_n;
   logic [NUM_REGS-1:0] log_mem [0:1023];
   int                  log_total = 0;

   always #5 clk = ~clk;

   spi_regbank #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .SYNC_STAGES(SYNC_STAGES)
   ) dut (
      .clk(clk), .rst(rst), .SCLK(SCLK), .SI(SI), .SV_n(SV_n), .SO(SO),
      .so_oe(so_oe), .regs(regs), .wr_strobe(wr_strobe), .busy(busy)
   );

   // every clk with a strobe bit set is logged, so a 2-clk pulse shows up twice
   always @(negedge clk) begin
      if (wr_strobe !== '0 && log_total < 1024) begin
         log_mem[log_total] = wr_strobe;
         log_total++;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] log_pack(input int start);
      logic [63:0] pk = '0;
      for (int j = start; j < log_total; j++) pk = {pk[55:0], log_mem[j]};
      return pk;
   endfunction

   function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
      logic [NUM_REGS*DATA_W-1:0] f;
      for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
      return f;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
   endtask

   task automatic model_write(input int addr, input int nw, input logic [63:0] data);
      int a;
      logic [NUM_REGS-1:0] oh;
      exp_pk = '0;
      exp_n  = 0;
      for (int k = 0; k < nw; k++) begin
         a = (addr + k) % (1 << ADDR_W);
         if (a < NUM_REGS) begin
            model[a] = data[(nw-1-k)*DATA_W +: DATA_W];
            oh = '0;
            oh[a] = 1'b1;
            exp_pk = {exp_pk[55:0], oh};
            exp_n++;
         end
      end
   endtask

   function automatic logic [63:0] model_read(input int addr, input int nw);
      logic [63:0] r = '0;
      int a;
      for (int k = 0; k < nw; k++) begin
         a = (addr + k) % (1 << ADDR_W);
         r = {r[55:0], (a < NUM_REGS) ? model[a] : 8'h00};
      end
      return r;
   endfunction

   task automatic spi_frame(input logic [63:0] bits, input int nbits, input bit keep_sel,
                            output logic [63:0] so_cap, output logic [63:0] oe_cap,
                            output logic busy_mid);
      so_cap   = '0;
      oe_cap   = '0;
      busy_mid = 1'b0;
      SV_n = 1'b0;
      tick(HALF);
      for (int i = nbits - 1; i >= 0; i--) begin
         SI = bits[i];
         tick(HALF);
         so_cap = {so_cap[62:0], SO};
         oe_cap = {oe_cap[62:0], so_oe};
         SCLK = 1'b1;
         tick(HALF);
         if (i == nbits - 1) busy_mid = busy;
         SCLK = 1'b0;
      end
      if (!keep_sel) begin
         tick(HALF);
         SV_n = 1'b1;
         tick(HALF + 4);
      end
   endtask

   task automatic do_frame(input bit rw, input int addr, input int nw, input logic [63:0] data,
                           output logic [63:0] so_cap, output logic [63:0] oe_cap,
                           output logic busy_mid);
      logic [63:0] bits;
      bits = (64'(rw) << (ADDR_W + nw*DATA_W)) | (64'(addr) << (nw*DATA_W)) | data;
      spi_frame(bits, 1 + ADDR_W + nw*DATA_W, 1'b0, so_cap, oe_cap, busy_mid);
   endtask

   task automatic test_reset();
      rst = 1'b1; SCLK = 1'b0; SI = 1'b0; SV_n = 1'b1;
      model_clear();
      tick(3);
      n_checks++; if (regs !== '0) $display("FAIL reset_regs: got %h expected 0", regs); else n_pass++;
      n_checks++; if (wr_strobe !== '0) $display("FAIL reset_strobe: got %h expected 0", wr_strobe); else n_pass++;
      n_checks++; if (SO !== 1'b0) $display("FAIL reset_SO: got %b expected 0", SO); else n_pass++;
      n_checks++; if (so_oe !== 1'b0) $display("FAIL reset_so_oe: got %b expected 0", so_oe); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      rst = 1'b0;
      tick(6);
      n_checks++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_write_basic();
      logic [63:0] so_c, oe_c;
      logic bm;
      int start = log_total;
      model_write(3, 1, 64'hA5);
      do_frame(1'b0, 3, 1, 64'hA5, so_c, oe_c, bm);
      n_checks++; if (regs[31:24] !== 8'hA5) $display("FAIL wr_reg3: got %h expected a5", regs[31:24]); else n_pass++;
      n_checks++; if (regs !== model_flat()) $display("FAIL wr_image: got %h expected %h", regs, model_flat()); else n_pass++;
      n_checks++;
      if (log_total - start != 1 || log_pack(start) !== 64'h08)
         $display("FAIL wr_strobe_seq: got n=%0d seq=%h expected n=1 seq=08", log_total - start, log_pack(start));
      else n_pass++;
      n_checks++; if (bm !== 1'b1) $display("FAIL wr_busy_mid: got %b expected 1", bm); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL wr_busy_end: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_read_basic();
      logic [63:0] so_c, oe_c;
      logic bm;
      int start = log_total;
      do_frame(1'b1, 3, 1, 64'h0, so_c, oe_c, bm);
      n_checks++; if (so_c[7:0] !== 8'hA5) $display("FAIL rd_so: got %h expected a5", so_c[7:0]); else n_pass++;
      n_checks++; if (oe_c[15:0] !== 16'h00FF) $display("FAIL rd_oe: got %h expected 00ff", oe_c[15:0]); else n_pass++;
      n_checks++; if (regs !== model_flat()) $display("FAIL rd_image: got %h expected %h", regs, model_flat()); else n_pass++;
      n_checks++; if (log_total != start) $display("FAIL rd_no_strobe: got %0d strobes expected 0", log_total - start); else n_pass++;
      n_checks++; if ({so_oe, SO} !== 2'b00) $display("FAIL rd_idle_pins: got %b expected 00", {so_oe, SO}); else n_pass++;
   endtask

   task automatic test_burst();
      logic [63:0] so_c, oe_c;
      logic bm;
      int start = log_total;
      model_write(6, 3, 64'h112233);
      do_frame(1'b0, 6, 3, 64'h112233, so_c, oe_c, bm);
      n_checks++; if (regs[63:48] !== 16'h2211) $display("FAIL burst_regs67: got %h expected 2211", regs[63:48]); else n_pass++;
      n_checks++; if (regs !== model_flat()) $display("FAIL burst_image: got %h expected %h", regs, model_flat()); else n_pass++;
      n_checks++;
      if (log_total - start != 2 || log_pack(start) !== 64'h4080)
         $display("FAIL burst_strobe_seq: got n=%0d seq=%h expected n=2 seq=4080", log_total - start, log_pack(start));
      else n_pass++;
   endtask

   task automatic test_partial();
      logic [63:0] so_c, oe_c;
      logic bm;
      int start = log_total;
      spi_frame(64'h36, 13, 1'b0, so_c, oe_c, bm);
      n_checks++; if (regs !== model_flat()) $display("FAIL partial_image: got %h expected %h", regs, model_flat()); else n_pass++;
      n_checks++; if (log_total != start) $display("FAIL partial_strobe: got %0d strobes expected 0", log_total - start); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL partial_busy: got %b expected 0", busy); else n_pass++;
   endtask

   task automatic test_read_oor();
      logic [63:0] so_c, oe_c;
      logic bm;
      do_frame(1'b1, 10, 1, 64'h0, so_c, oe_c, bm);
      n_checks++; if (so_c[7:0] !== 8'h00) $display("FAIL oor_so: got %h expected 00", so_c[7:0]); else n_pass++;
      n_checks++; if (oe_c[15:0] !== 16'h00FF) $display("FAIL oor_oe: got %h expected 00ff", oe_c[15:0]); else n_pass++;
   endtask

   task automatic test_reset_midframe();
      logic [63:0] so_c, oe_c;
      logic bm;
      int start;
      spi_frame(64'h0B, 10, 1'b1, so_c, oe_c, bm);
      rst = 1'b1;
      tick(2);
      n_checks++;
      if ({regs, wr_strobe, SO, so_oe, busy} !== '0)
         $display("FAIL midrst_outputs: got regs=%h strobe=%h so=%b oe=%b busy=%b expected all 0",
                  regs, wr_strobe, SO, so_oe, busy);
      else n_pass++;
      rst = 1'b0;
      model_clear();
      tick(6);
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_wait_busy: got %b expected 0", busy); else n_pass++;
      SV_n = 1'b1;
      tick(10);
      start = log_total;
      model_write(2, 1, 64'h5A);
      do_frame(1'b0, 2, 1, 64'h5A, so_c, oe_c, bm);
      n_checks++; if (regs !== 64'h0000_0000_005A_0000) $display("FAIL midrst_write: got %h expected 00000000005a0000", regs); else n_pass++;
      n_checks++;
      if (log_total - start != 1 || log_pack(start) !== 64'h04)
         $display("FAIL midrst_strobe_seq: got n=%0d seq=%h expected n=1 seq=04", log_total - start, log_pack(start));
      else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] so_c, oe_c, data, exp_so, mask;
      logic bm;
      bit   rw;
      int   addr, nw, start;
      for (int it = 0; it < 40; it++) begin
         rw   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(124, 127)) : int'($urandom_range(0, 11));
         nw   = $urandom_range(1, 3);
         mask = (64'd1 << (nw*DATA_W)) - 64'd1;
         data = {$urandom, $urandom} & mask;
         start = log_total;
         exp_so = model_read(addr, nw);
         exp_pk = '0;
         exp_n  = 0;
         if (!rw) model_write(addr, nw, data);
         do_frame(rw, addr, nw, data, so_c, oe_c, bm);
         n_checks++; if (bm !== 1'b1) $display("FAIL rnd_busy_mid it=%0d: got %b expected 1", it, bm); else n_pass++;
         n_checks++;
         if (oe_c !== (rw ? mask : 64'h0)) $display("FAIL rnd_oe it=%0d: got %h expected %h", it, oe_c, rw ? mask : 64'h0);
         else n_pass++;
         if (rw) begin
            n_checks++;
            if ((so_c & mask) !== exp_so) $display("FAIL rnd_so it=%0d a=%0d: got %h expected %h", it, addr, so_c & mask, exp_so);
            else n_pass++;
         end
         n_checks++; if (regs !== model_flat()) $display("FAIL rnd_image it=%0d: got %h expected %h", it, regs, model_flat()); else n_pass++;
         n_checks++;
         if (log_total - start != exp_n || log_pack(start) !== exp_pk)
            $display("FAIL rnd_strobe_seq it=%0d: got n=%0d seq=%h expected n=%0d seq=%h",
                     it, log_total - start, log_pack(start), exp_n, exp_pk);
         else n_pass++;
         n_checks++; if (busy !== 1'b0) $display("FAIL rnd_busy_end it=%0d: got %b expected 0", it, busy); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_basic();
      test_burst();
      test_partial();
      test_read_oor();
      test_reset_midframe();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/spi_regbank.md
SPI_REGBANK -- requirements
Module: spi_regbank

Interface
REQ-001 Parameter DATA_W, default 8: data word width in bits, 8..32.
REQ-002 Parameter ADDR_W, default 7: address field width in bits, 1..15.
REQ-003 Parameter NUM_REGS, default 8: number of implemented registers, 1..2**ADDR_W.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth for SPI pins, minimum 2.
REQ-005 clk  input  1  system clock; the only clock in the block; SPI pins are oversampled on it.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 SI  input  1  SPI serial data in, MSB first.
REQ-009 SV_n  input  1  SPI select, active-low, asynchronous to clk.
REQ-010 SO  output  1  SPI serial data out, MSB first; 0 when not driving read data.
REQ-011 so_oe  output  1  high while in a read data phase; external pad enable.
REQ-012 regs  output  NUM_REGS*DATA_W  flat register image; register i occupies bits [i*DATA_W +: DATA_W].
REQ-013 wr_strobe  output  NUM_REGS  one-clk pulse on bit i when register i is written.
REQ-014 busy  output  1  high while a frame is in progress (SV_n low, synchronised).

Function
REQ-015 SCLK, SI and SV_n shall each pass through SYNC_STAGES flops on clk; edge detection shall use the last two synchronised samples.
REQ-016 Operation shall be correct when SCLK high and low times are each at least SYNC_STAGES+2 clk periods.
REQ-017 Frame format: 1 R/W bit (1 = read, 0 = write), ADDR_W address bits, then one or more DATA_W data words.
REQ-018 States: IDLE, CMD, DATA; IDLE -> CMD on synchronised SV_n fall, with bit counter cleared.
REQ-019 In CMD and DATA, each synchronised SCLK rise shall shift SI into the input shift register and increment the bit counter.
REQ-020 CMD -> DATA on the rise completing 1+ADDR_W bits; R/W and address shall be latched into a working address pointer.
REQ-021 Write word: on the rise completing DATA_W data bits, the word shall be committed to the register at the pointer one clk later, together with a one-clk wr_strobe pulse for that register.
REQ-022 Write to pointer >= NUM_REGS shall be discarded with no strobe.
REQ-023 Read: on the first SCLK fall in DATA, the shift-out register shall load the register at the pointer, or 0 if the pointer >= NUM_REGS, with SO = bit DATA_W-1.
REQ-024 Read: each subsequent fall within the word shall shift the shift-out register by one bit toward SO.
REQ-025 Read data shall be the register value sampled at the load instant; a write in the same clk shall not alter the bits already loaded.
REQ-026 Burst: after each completed data word, the pointer shall increment modulo 2**ADDR_W and the bit counter shall restart the data word, for both read and write.
REQ-027 so_oe shall be high from the first DATA-phase fall of a read frame until IDLE; SO shall be 0 whenever so_oe is low.
REQ-028 Synchronised SV_n rise in any state -> IDLE, discarding any incomplete word; busy shall drop in the same clk.
REQ-029 A word completed by a SCLK rise detected in the same clk as the SV_n rise shall be committed.
REQ-030 A frame ended during CMD shall cause no register access.
REQ-031 An SV_n fall while in CMD/DATA is impossible by construction; a new frame shall only start from IDLE.

Reset
REQ-032 While rst is high: state IDLE, all regs 0, wr_strobe 0, SO 0, so_oe 0, busy 0, counters, pointer and shift registers 0, synchroniser flops 1 for SV_n and 0 for SCLK/SI.
REQ-033 rst asserted mid-frame shall abort the frame immediately; after release the block shall wait for a fresh SV_n fall.

Verification (defaults)
REQ-034 Write frame 0_0000011_10100101 -> regs[31:24]=0xA5, wr_strobe[3] high for exactly 1 clk, other registers 0.
REQ-035 After REQ-034, read frame 1_0000011 plus 8 clocks -> SO bits 1,0,1,0,0,1,0,1 sampled on rises, so_oe high, regs unchanged.
REQ-036 Burst write 0_0000110 followed by 0x11, 0x22, 0x33 -> reg6=0x11, reg7=0x22, 0x33 dropped (pointer 8 >= NUM_REGS); strobes 6 then 7 only.
REQ-037 Write frame 0_0000001 followed by 5 data bits, then SV_n high -> reg1 unchanged, no strobe, busy low, state IDLE.
REQ-038 Read frame 1_0001010 (address 10) -> SO = 0x00 over 8 clocks.
REQ-039 rst pulsed after 10 bits of a write frame -> all outputs 0; next complete write frame to reg2 = 0x5A succeeds.
